// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: R0 (core) has fixed
// priority, R1 (loader) is forced through after STARVE_MAX consecutive losses.

module dm_port_ret #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_fire,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);
    // rdata holds its last value between reads; only rvalid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_fire;
            if (rd_fire) rdata <= mem_rdata;
        end
    end
endmodule

module dm_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          starved
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0]         starve_cnt;
    logic                  frc;
    logic [1:0]            rd_fire;
    logic [1:0]            rvalid;
    logic [1:0][DW-1:0]    rdata;

    assign frc     = req1 && (starve_cnt == CW'(STARVE_MAX));
    assign gnt1    = req1 && (!req0 || frc);
    assign gnt0    = req0 && !gnt1;
    assign starved = req1 && gnt0;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gnt1) begin
            mem_addr  = addr1;
            mem_we    = we1;
            mem_wdata = wdata1;
        end else if (gnt0) begin
            mem_addr  = addr0;
            mem_we    = we0;
            mem_wdata = wdata0;
        end
    end

    // Counts R0 wins while R1 waits; any R1 grant or dropped R1 request clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (gnt1 || !req1)
            starve_cnt <= '0;
        else if (gnt0 && starve_cnt != CW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign rd_fire = {gnt1 && !we1, gnt0 && !we0};

    for (genvar i = 0; i < 2; i++) begin : g_ret
        dm_port_ret #(.DW(DW)) u_ret (
            .clk       (clk),
            .rst_n     (rst_n),
            .rd_fire   (rd_fire[i]),
            .mem_rdata (mem_rdata),
            .rvalid    (rvalid[i]),
            .rdata     (rdata[i])
        );
    end

    assign rvalid0 = rvalid[0];
    assign rvalid1 = rvalid[1];
    assign rdata0  = rdata[0];
    assign rdata1  = rdata[1];
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed cases plus randomized traffic against a
// cycle-level behavioural model of the port, with its own memory image.
module tb_dm_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we, starved;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] dm      [0:255];
    logic [DW-1:0] ref_mem [0:255];

    int vecs = 0;
    int errs = 0;

    dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starved(starved)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    assign mem_rdata = dm[mem_addr];
    always @(posedge clk) if (mem_we) dm[mem_addr] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: R1's run of losses, pending read returns, memory contents.
    bit            chk_en = 1'b0;
    int            m_wait;
    int            r1_wait;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;
    bit            e0, e1, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_wait = 0; r1_wait = 0;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
        end else if (chk_en) begin
            // R1 wins if R0 is idle or R1 has already lost SM times in a row.
            e1 = req1 && (!req0 || m_wait >= SM);
            e0 = req0 && !e1;
            ea = '0; ewe = 1'b0; ew = '0;
            if (e1)      begin ea = addr1; ewe = we1; ew = wdata1; end
            else if (e0) begin ea = addr0; ewe = we0; ew = wdata0; end
            chk("gnt0", gnt0, e0);
            chk("gnt1", gnt1, e1);
            chk("excl", gnt0 && gnt1, 0);
            chk("mem_addr", mem_addr, ea);
            chk("mem_we", mem_we, ewe);
            chk("mem_wdata", mem_wdata, ew);
            chk("starved", starved, req1 && e0);
            chk("rvalid0", rvalid0, m_rv0);
            chk("rdata0", rdata0, m_rd0);
            chk("rvalid1", rvalid1, m_rv1);
            chk("rdata1", rdata1, m_rd1);
            if (req1 && gnt0) r1_wait++; else r1_wait = 0;
            chk("starve_bound", r1_wait > SM, 0);
            m_rv0 = e0 && !we0;
            m_rv1 = e1 && !we1;
            if (m_rv0) m_rd0 = ref_mem[addr0];
            if (m_rv1) m_rd1 = ref_mem[addr1];
            if (ewe) ref_mem[ea] = ew;
            if (!req1 || e1) m_wait = 0;
            else if (m_wait < SM) m_wait++;
        end
    end

    task automatic drive(input bit r0, input bit w0, input int a0, input int d0,
                         input bit r1, input bit w1, input int a1, input int d1);
        req0 = r0; we0 = w0; addr0 = AW'(a0); wdata0 = DW'(d0);
        req1 = r1; we1 = w1; addr1 = AW'(a1); wdata1 = DW'(d1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    bit g0, g1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dm[i] = DW'($urandom);
            ref_mem[i] = dm[i];
        end
        dm[64] = 8'd70; ref_mem[64] = 8'd70;
        dm[94] = 8'd0;  ref_mem[94] = 8'd0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        step();
        rst_n = 1'b1; chk_en = 1'b1;

        // R0 reads addr 64 alone
        drive(1, 0, 64, 0, 0, 0, 0, 0);
        @(negedge clk); chk("t2_gnt0", gnt0, 1);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("t2_rvalid0", rvalid0, 1); chk("t2_rdata0", rdata0, 70);
        step();
        @(negedge clk); chk("t2_rvalid0_drop", rvalid0, 0);
        step();

        // R1 writes addr 203 alone
        drive(0, 0, 0, 0, 1, 1, 203, 64);
        @(negedge clk); chk("t3_gnt1", gnt1, 1); chk("t3_mem_we", mem_we, 1);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_dm203", dm[203], 64);
        @(negedge clk); chk("t3_rvalid1", rvalid1, 0);
        step();

        // Both held: R1 forced every fifth cycle
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 10 + i, 0, 1, 0, 20 + i, 0);
            @(negedge clk);
            chk("t4_gnt1", gnt1, (i % 5) == 4);
            chk("t4_starved", starved, (i % 5) != 4);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); step();

        // Same-address conflict: R0 read wins, R1 write follows
        drive(1, 0, 94, 0, 1, 1, 94, 9);
        @(negedge clk); chk("t5_gnt0", gnt0, 1); chk("t5_gnt1", gnt1, 0);
        step(); drive(0, 0, 0, 0, 1, 1, 94, 9);
        @(negedge clk); chk("t5_gnt1b", gnt1, 1); chk("t5_rvalid0", rvalid0, 1); chk("t5_rdata0", rdata0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_dm94", dm[94], 9);
        @(negedge clk); step();

        // Mid-run asynchronous reset with a read return pending and the counter at 3
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 64, 0, 1, 0, 30, 0);
            @(negedge clk); step();
        end
        chk("t1_rvalid0_pre", rvalid0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rvalid0", rvalid0, 0);
        chk("t1_rvalid1", rvalid1, 0);
        chk("t1_rdata0", rdata0, 0);
        chk("t1_rdata1", rdata1, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 40, 0, 1, 0, 50, 0);
            @(negedge clk); chk("t1_cnt_cleared", gnt0, i < 4);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); step();

        // Randomized traffic; requests held until granted, occasionally abandoned
        g0 = 1'b0; g1 = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (!req0 || g0) begin
                req0 = ($urandom_range(0, 9) < 6);
                we0 = 1'($urandom);
                if ($urandom_range(0, 3) == 0) addr0 = AW'($urandom); else addr0 = AW'($urandom_range(0, 15));
                wdata0 = DW'($urandom);
            end else if ($urandom_range(0, 49) == 0) req0 = 1'b0;
            if (!req1 || g1) begin
                req1 = ($urandom_range(0, 9) < 6);
                we1 = 1'($urandom);
                if ($urandom_range(0, 3) == 0) addr1 = AW'($urandom); else addr1 = AW'($urandom_range(0, 15));
                wdata1 = DW'($urandom);
            end else if ($urandom_range(0, 49) == 0) req1 = 1'b0;
            @(negedge clk); g0 = gnt0; g1 = gnt1;
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 256; i++)
            if (dm[i] !== ref_mem[i]) chk("final_mem", dm[i], ref_mem[i]);
        chk("final_mem_64", dm[64], ref_mem[64]);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
